sel_n_1_scan: RTL and testbench

Parametrised N-input, W-bit registered selector, successor to the 2:1 selector. It adds a clocked output stage, a per-channel enable mask, and an automatic scan mode that dwells a programmable number of cycles on each enabled channel. It sits between multiple data sources and a single downstream consumer such as a display, logger or serial shifter.

---
 rtl/sel_pkg.sv | 19 +
 rtl/sel_next_ch.sv | 29 ++
 rtl/sel_n_1_scan.sv | 98 +++++++++
 tb/tb_sel_n_1_scan.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared definitions for the registered N:1 selector family: mode constants,
// state encoding and a width helper that never returns zero.
package sel_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // $clog2 of 1 or 2 would give a zero/one-bit width; keep at least one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sel_next_ch.sv
// Combinational circular priority finder: first set bit of mask searching
// upward from start+1, wrapping N-1 -> 0 and ending at start itself.
module sel_next_ch import sel_pkg::*; #(
    parameter int N = 4,
    localparam int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] start,
    output logic [SW-1:0] next_idx,
    output logic          found
);

    int idx;

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        idx      = 0;
        // i == N lands back on start, so a lone enabled channel finds itself.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(start) + i) % N;
            if (!found && mask[idx[SW-1:0]]) begin
                found    = 1'b1;
                next_idx = idx[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/sel_n_1_scan.sv
// Registered N:1 selector with per-channel enable mask and an automatic scan
// mode that dwells DWELL cycles on each enabled channel.
module sel_n_1_scan import sel_pkg::*; #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 4,
    localparam int SW   = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in,
    input  logic [SW-1:0]  sel_in,
    input  logic           mode,
    input  logic           en,
    input  logic [N-1:0]   ch_en,
    output logic [W-1:0]   out,
    output logic [SW-1:0]  out_sel,
    output logic           out_valid,
    output logic           ch_done,
    output logic [1:0]     dbg_state
);

    localparam int CW = clog2_min1(DWELL);

    state_t         state;
    logic [CW-1:0]  cnt;
    // scan_ch is the channel to present next; out_sel trails it by one edge
    // so that out_sel always names the data currently on out.
    logic [SW-1:0]  scan_ch;
    logic [SW-1:0]  nxt_ch;
    logic           nxt_found;
    logic           sel_ok;

    assign sel_ok    = ({1'b0, sel_in} < (SW+1)'(N));
    assign dbg_state = state;

    sel_next_ch #(.N(N)) u_next_ch (
        .mask     (ch_en),
        .start    (scan_ch),
        .next_idx (nxt_ch),
        .found    (nxt_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            scan_ch   <= '0;
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ch_done   <= 1'b0;
        end else begin
            ch_done <= 1'b0;
            if (!en) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                cnt       <= '0;
            end else if (mode == MODE_MANUAL) begin
                state <= ST_MANUAL;
                cnt   <= '0;
                if (sel_ok) begin
                    out       <= in[sel_in*W +: W];
                    out_sel   <= sel_in;
                    scan_ch   <= sel_in;
                    out_valid <= ch_en[sel_in];
                end else begin
                    out_valid <= 1'b0;
                end
            end else begin
                state <= ST_SCAN;
                if (!nxt_found) begin
                    // Empty mask: park on the current channel.
                    out_valid <= 1'b0;
                    cnt       <= '0;
                end else if (!ch_en[scan_ch]) begin
                    // Channel vanished mid-dwell: jump without a done pulse.
                    scan_ch   <= nxt_ch;
                    out_sel   <= nxt_ch;
                    out_valid <= 1'b0;
                    cnt       <= '0;
                end else begin
                    out       <= in[scan_ch*W +: W];
                    out_sel   <= scan_ch;
                    out_valid <= 1'b1;
                    if (cnt == CW'(DWELL - 1)) begin
                        ch_done <= 1'b1;
                        cnt     <= '0;
                        scan_ch <= nxt_ch;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sel_n_1_scan.sv
// Directed bench for sel_n_1_scan (N=4, W=8, DWELL=4): manual select, scan
// sequencing, mask changes, enable freeze and asynchronous reset.
module tb_sel_n_1_scan;
    import sel_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_bus;
    logic [1:0]  sel_in;
    logic        mode;
    logic        en;
    logic [3:0]  ch_en;
    logic [7:0]  out;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        ch_done;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [7:0] man_exp [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
    int         scan_sel [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    int         alt_sel [14]  = '{1,1,1,1,3,3,3,3,1,1,1,1,3,3};
    int         alt_done [14] = '{0,0,0,1,0,0,0,1,0,0,0,1,0,0};
    int         rst_sel [5]   = '{0,0,0,0,1};
    int         rst_done [5]  = '{0,0,0,1,0};

    sel_n_1_scan #(.N(4), .W(8), .DWELL(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_bus),
        .sel_in    (sel_in),
        .mode      (mode),
        .en        (en),
        .ch_en     (ch_en),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .ch_done   (ch_done),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        in_bus = {8'h44, 8'h33, 8'h22, 8'h11};
        sel_in = 2'd0;
        mode   = MODE_MANUAL;
        en     = 1'b0;
        ch_en  = 4'h0;
        #12;
        chk("rst_out", out, 8'h00);
        chk("rst_sel", out_sel, 2'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_done", ch_done, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;

        // Manual stepping through all channels
        en    = 1'b1;
        ch_en = 4'hF;
        for (int s = 0; s < 4; s++) begin
            sel_in = 2'(s);
            tick();
            chk("man_out", out, man_exp[s]);
            chk("man_sel", out_sel, 32'(s));
            chk("man_valid", out_valid, 1'b1);
        end
        chk("man_state", dbg_state, ST_MANUAL);

        // Park on channel 0, then scan the full mask
        sel_in = 2'd0;
        tick();
        chk("park_sel", out_sel, 2'd0);
        mode = MODE_SCAN;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("scan_sel", out_sel, 32'(scan_sel[k]));
            chk("scan_out", out, man_exp[scan_sel[k]]);
            chk("scan_done", ch_done, ((k + 1) % 4 == 0) ? 1'b1 : 1'b0);
            chk("scan_valid", out_valid, 1'b1);
        end
        chk("scan_state", dbg_state, ST_SCAN);

        // Sparse mask: channel 0 disappears mid-dwell
        ch_en = 4'b1010;
        tick();
        chk("alt_jump_sel", out_sel, 2'd1);
        chk("alt_jump_valid", out_valid, 1'b0);
        chk("alt_jump_done", ch_done, 1'b0);
        for (int k = 0; k < 14; k++) begin
            tick();
            chk("alt_sel", out_sel, 32'(alt_sel[k]));
            chk("alt_out", out, man_exp[alt_sel[k]]);
            chk("alt_done", ch_done, 32'(alt_done[k]));
        end

        // Clear channel 3 mid-dwell
        ch_en = 4'b0010;
        tick();
        chk("drop3_sel", out_sel, 2'd1);
        chk("drop3_done", ch_done, 1'b0);
        chk("drop3_valid", out_valid, 1'b0);
        tick();
        chk("drop3_next_out", out, 8'h22);
        chk("drop3_next_valid", out_valid, 1'b1);

        // Empty mask: frozen, never done
        ch_en = 4'h0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("empty_valid", out_valid, 1'b0);
            chk("empty_sel", out_sel, 2'd1);
            chk("empty_done", ch_done, 1'b0);
        end
        ch_en = 4'b0100;
        tick();
        chk("reen_sel", out_sel, 2'd2);
        tick();
        chk("reen_out", out, 8'h33);
        chk("reen_valid", out_valid, 1'b1);
        tick();

        // Enable dropped mid-dwell: output holds even though input changes
        en = 1'b0;
        in_bus[23:16] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_out", out, 8'h33);
            chk("idle_valid", out_valid, 1'b0);
            chk("idle_sel", out_sel, 2'd2);
            chk("idle_done", ch_done, 1'b0);
        end
        chk("idle_state", dbg_state, ST_IDLE);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("resume_out", out, 8'h5A);
            chk("resume_valid", out_valid, 1'b1);
            chk("resume_done", ch_done, (k == 3) ? 1'b1 : 1'b0);
        end
        tick();
        chk("solo_sel", out_sel, 2'd2);
        chk("solo_done", ch_done, 1'b0);

        // Asynchronous reset mid-scan on channel 2
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", out, 8'h00);
        chk("arst_sel", out_sel, 2'd0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_done", ch_done, 1'b0);
        ch_en = 4'hF;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_sel", out_sel, 32'(rst_sel[k]));
            chk("post_rst_out", out, man_exp[rst_sel[k]]);
            chk("post_rst_done", ch_done, 32'(rst_done[k]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
